// File: rtl/hazard_unit_mc_if.sv
// -----------------------------------------------------------------------------
// hazard_unit_mc_if
// Bundles the pipeline-side signals seen by the hazard controller.
//   master : pipeline side. Drives register addresses, write enables, load/
//            branch/mul-div/memory status. Receives stall, flush and forwarding.
//   slave  : hazard controller side. The same signals with opposite directions.
// stall_count is carried here as well, so that one interface instance
// represents the whole controller port list apart from clk/rst_n.
// -----------------------------------------------------------------------------
interface hazard_unit_mc_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] rs1_d;
    logic [REG_ADDR_W-1:0] rs2_d;
    logic [REG_ADDR_W-1:0] rs1_e;
    logic [REG_ADDR_W-1:0] rs2_e;
    logic [REG_ADDR_W-1:0] rd_e;
    logic [1:0]            result_src_e;
    logic                  pc_src_e;
    logic                  md_start_e;
    logic                  md_done;
    logic [REG_ADDR_W-1:0] rd_m;
    logic                  reg_write_m;
    logic                  dmem_req_m;
    logic                  dmem_ready;
    logic [REG_ADDR_W-1:0] rd_w;
    logic                  reg_write_w;

    logic                  stall_f;
    logic                  stall_d;
    logic                  stall_e;
    logic                  stall_m;
    logic                  flush_d;
    logic                  flush_e;
    logic                  flush_m;
    logic                  flush_w;
    logic                  forward_rd1_d;
    logic                  forward_rd2_d;
    logic [1:0]            forward_a_e;
    logic [1:0]            forward_b_e;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e, pc_src_e,
               md_start_e, md_done, rd_m, reg_write_m, dmem_req_m,
               dmem_ready, rd_w, reg_write_w,
        input  stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_m, flush_w,
               forward_rd1_d, forward_rd2_d, forward_a_e, forward_b_e,
               stall_count
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e, pc_src_e,
               md_start_e, md_done, rd_m, reg_write_m, dmem_req_m,
               dmem_ready, rd_w, reg_write_w,
        output stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_m, flush_w,
               forward_rd1_d, forward_rd2_d, forward_a_e, forward_b_e,
               stall_count
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// -----------------------------------------------------------------------------
// hazard_unit_mc
// Hazard controller for the 5-stage F/D/E/M/W core. Produces per-stage stall
// and flush controls, D-stage and E-stage forwarding selects, sequences the
// iterative mul/div start/done handshake, absorbs data-memory wait states and
// keeps a saturating count of front-end stall cycles.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   hz     : hazard_unit_mc_if.slave (pipeline status in, controls out)
//
// State table
//   state   | meaning
//   RUN     | normal issue; detects mul/div issue, load-use and branches
//   LDSTALL | extra load-use bubbles, counted down by ld_cnt
//   MDWAIT  | waiting for md_done from the mul/div unit
// -----------------------------------------------------------------------------
module hazard_unit_mc #(
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_unit_mc_if.slave  hz
);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
    localparam logic [2:0] LD_RELOAD = 3'(LOAD_USE_STALL - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MDWAIT  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [2:0]       ld_cnt_q;
    logic [2:0]       ld_cnt_nxt;
    logic [CNT_W-1:0] stall_count_q;

    logic memwait;
    logic lduse;
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;

    // Only bit 0 of result_src_e identifies a load.
    logic unused_result_src;
    assign unused_result_src = hz.result_src_e[1];

    // Forwarding: M has priority over W, register 0 never forwards.
    always_comb begin
        hz.forward_a_e = 2'b00;
        if (hz.reg_write_m && hz.rs1_e == hz.rd_m && hz.rs1_e != REG_ZERO)
            hz.forward_a_e = 2'b10;
        else if (hz.reg_write_w && hz.rs1_e == hz.rd_w && hz.rs1_e != REG_ZERO)
            hz.forward_a_e = 2'b01;

        hz.forward_b_e = 2'b00;
        if (hz.reg_write_m && hz.rs2_e == hz.rd_m && hz.rs2_e != REG_ZERO)
            hz.forward_b_e = 2'b10;
        else if (hz.reg_write_w && hz.rs2_e == hz.rd_w && hz.rs2_e != REG_ZERO)
            hz.forward_b_e = 2'b01;
    end

    assign hz.forward_rd1_d = hz.reg_write_w && hz.rs1_d == hz.rd_w && hz.rs1_d != REG_ZERO;
    assign hz.forward_rd2_d = hz.reg_write_w && hz.rs2_d == hz.rd_w && hz.rs2_d != REG_ZERO;

    assign memwait = hz.dmem_req_m && !hz.dmem_ready;
    assign lduse   = hz.result_src_e[0] && hz.rd_e != REG_ZERO &&
                     (hz.rs1_d == hz.rd_e || hz.rs2_d == hz.rd_e);

    always_comb begin
        state_nxt  = state_q;
        ld_cnt_nxt = ld_cnt_q;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        stall_m    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        flush_m    = 1'b0;
        flush_w    = 1'b0;

        if (!rst_n) begin
            state_nxt  = RUN;
            ld_cnt_nxt = 3'd0;
        end else if (memwait) begin
            // Whole pipe freezes; W gets a bubble so the retiring instruction
            // is not written twice. A done pulse must not be lost here.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
            if (state_q == MDWAIT && hz.md_done)
                state_nxt = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hz.md_start_e && !hz.md_done) begin
                        stall_f   = 1'b1;
                        stall_d   = 1'b1;
                        stall_e   = 1'b1;
                        flush_m   = 1'b1;
                        state_nxt = MDWAIT;
                    end else if (lduse) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                        if (LOAD_USE_STALL > 1) begin
                            ld_cnt_nxt = LD_RELOAD;
                            state_nxt  = LDSTALL;
                        end
                    end else if (hz.pc_src_e) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                LDSTALL: begin
                    // E holds a bubble, so pc_src_e cannot be genuine here.
                    stall_f    = 1'b1;
                    stall_d    = 1'b1;
                    flush_e    = 1'b1;
                    ld_cnt_nxt = ld_cnt_q - 3'd1;
                    if (ld_cnt_q == 3'd1)
                        state_nxt = RUN;
                end
                MDWAIT: begin
                    if (hz.md_done) begin
                        state_nxt = RUN;
                        if (hz.pc_src_e) begin
                            flush_d = 1'b1;
                            flush_e = 1'b1;
                        end
                    end else begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                    end
                end
                default: begin
                    state_nxt  = RUN;
                    ld_cnt_nxt = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            ld_cnt_q      <= 3'd0;
            stall_count_q <= '0;
        end else begin
            state_q  <= state_nxt;
            ld_cnt_q <= ld_cnt_nxt;
            if (stall_f && stall_count_q != {CNT_W{1'b1}})
                stall_count_q <= stall_count_q + 1'b1;
        end
    end

    assign hz.stall_f     = stall_f;
    assign hz.stall_d     = stall_d;
    assign hz.stall_e     = stall_e;
    assign hz.stall_m     = stall_m;
    assign hz.flush_d     = flush_d;
    assign hz.flush_e     = flush_e;
    assign hz.flush_m     = flush_m;
    assign hz.flush_w     = flush_w;
    assign hz.stall_count = stall_count_q;

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Multi-cycle-aware pipeline hazard controller for the 5-stage (F/D/E/M/W) core. It generates per-stage stall and flush controls, and forwarding selects for both D-stage register reads and E-stage ALU operands. It adds a register-file address-width parameter and a configurable load-use penalty. It also handles a start/done handshake to the iterative mul/div unit, data-memory wait states and a saturating stall-cycle counter. It sits beside the pipeline registers and drives their enable/clear inputs.

## Interface
- REG_ADDR_W, 5: register address width; register 0 is hardwired zero.
- LOAD_USE_STALL, 1: stall cycles per load-use hazard, legal 1..7.
- CNT_W, 16: width of stall_count.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs1_d, rs2_d  in  REG_ADDR_W  source registers of the instruction in D.
- rs1_e, rs2_e, rd_e  in  REG_ADDR_W  source and destination registers in E.
- result_src_e  in  2  bit0=1 marks a load in E.
- pc_src_e  in  1  taken branch or jump resolved in E.
- md_start_e  in  1  mul/div instruction in E, issuing this cycle.
- md_done  in  1  mul/div result valid, single-cycle pulse.
- rd_m, reg_write_m  in  REG_ADDR_W, 1  M-stage destination and write enable.
- dmem_req_m, dmem_ready  in  1, 1  M-stage memory access and its completion.
- rd_w, reg_write_w  in  REG_ADDR_W, 1  W-stage destination and write enable.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the corresponding pipeline register.
- flush_d, flush_e, flush_m, flush_w  out  1  load a bubble into the corresponding register.
- forward_rd1_d, forward_rd2_d  out  1  D-stage read takes the W result.
- forward_a_e, forward_b_e  out  2  E-operand select: 00 regfile, 01 W, 10 M.
- stall_count  out  CNT_W  saturating count of cycles with stall_f=1.

## Operation
- FSM states are RUN, LDSTALL, MDWAIT. A down-counter ld_cnt (3 bits) is used in LDSTALL.
- Forwarding is combinational in all states:
  - forward_a_e = 10 if rs1_e==rd_m & reg_write_m & rs1_e!=0.
  - Otherwise forward_a_e = 01 if rs1_e==rd_w & reg_write_w & rs1_e!=0.
  - Otherwise forward_a_e = 00. forward_b_e follows the same rule with rs2_e.
  - forward_rdN_d = rsN_d==rd_w & reg_write_w & rsN_d!=0.
- lduse = result_src_e[0] & rd_e!=0 & (rs1_d==rd_e | rs2_d==rd_e).
- memwait = dmem_req_m & !dmem_ready. It has the highest priority in every state:
  - stall_f/d/e/m=1 and flush_w=1. All other flushes are 0.
  - The FSM holds its state and ld_cnt is frozen.
  - md_done arriving during memwait is still honoured: MDWAIT moves to RUN.
- RUN:
  - md_start_e: stall_f/d/e=1, flush_m=1. Go to MDWAIT unless md_done is also high in the same cycle.
  - Otherwise lduse: stall_f/d=1, flush_e=1. If LOAD_USE_STALL>1, load ld_cnt=LOAD_USE_STALL-1 and go to LDSTALL.
  - Otherwise pc_src_e: flush_d=1, flush_e=1.
- LDSTALL:
  - Each cycle: stall_f/d=1, flush_e=1, ld_cnt decrements.
  - When ld_cnt==1, go to RUN.
  - pc_src_e is ignored here, because E holds a bubble.
- MDWAIT:
  - Each cycle: stall_f/d/e=1, flush_m=1.
  - On md_done: release all stalls in that same cycle, apply flush_m=0 and go to RUN.
  - pc_src_e has no effect while stall_e=1.
  - In the md_done cycle, a pc_src_e=1 produces flush_d/e=1.
- Branch flushes are applied only in cycles where stall_e=0 and memwait=0.
- stall_count increments every cycle with stall_f=1 and saturates at all-ones.
- Reset: state=RUN, ld_cnt=0, stall_count=0. While rst_n=0, all stall and flush outputs are forced to 0. Forwarding outputs remain combinational.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the current state, in the same cycle.
- State, ld_cnt and stall_count update on the rising clk edge.
- A load-use hazard costs exactly LOAD_USE_STALL cycles of stall_f, plus any memwait cycles.
- A mul/div operation stalls from the md_start_e cycle through the md_done cycle minus one. md_done in the start cycle gives zero stall.
- rst_n assertion is asynchronous and aborts LDSTALL or MDWAIT immediately. Deassertion takes effect at the next edge.

## Test plan
- rs1_e=3, rd_m=3, reg_write_m=1, rd_w=3, reg_write_w=1 -> forward_a_e=10. Same with rs1_e=0 -> 00.
- LOAD_USE_STALL=3: load with rd_e=5, rs2_d=5 -> stall_f=1 and flush_e=1 for exactly 3 cycles, then RUN. stall_count ends at 3.
- md_start_e pulse, md_done 4 cycles later -> stall_f/d/e=1 and flush_m=1 for 4 cycles, released in the md_done cycle.
- memwait asserted for 2 cycles during LDSTALL -> all four stalls and flush_w held for 2 cycles. The load-use stall resumes afterwards, 5 stall cycles in total.
- pc_src_e=1 in RUN -> flush_d=flush_e=1 for one cycle. pc_src_e=1 during MDWAIT -> no flush until the md_done cycle.
- rst_n driven low mid-MDWAIT -> all stalls drop immediately. After release, state is RUN and stall_count=0.
- stall_count with CNT_W=2 -> saturates at 3.
